// File: rtl/enemy_draw_scheduler.sv
// Round-robin arbiter and pixel sequencer sharing one VGA plot port between
// the enemy and player sprites; enemy redraws erase the previous box first.
module enemy_draw_scheduler #(
  parameter int unsigned BOX_W         = 16,
  parameter int unsigned BOX_H         = 16,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  ENEMY_COLOUR  = 3'b100,
  parameter logic [2:0]  PLAYER_COLOUR = 3'b010
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enemy_req,
  input  logic [7:0] enemy_x,
  input  logic [6:0] enemy_y,
  input  logic       player_req,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       enemy_ack,
  output logic       player_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E_ERASE = 3'd1,
    E_DRAW  = 3'd2,
    P_DRAW  = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_ENEMY  = 1'b0,
    GRANT_PLAYER = 1'b1
  } grant_e;

  // Box dimensions are at most 16, so 4-bit counters always suffice.
  localparam logic [3:0] CX_LAST = 4'(BOX_W - 1);
  localparam logic [3:0] CY_LAST = 4'(BOX_H - 1);

  state_e     state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic [3:0] cx_q, cx_d;
  logic [3:0] cy_q, cy_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [7:0] prev_x_q, prev_x_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic       prev_valid_q, prev_valid_d;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       write_en_q, write_en_d;
  logic       enemy_ack_q, enemy_ack_d;
  logic       player_ack_q, player_ack_d;
  logic       busy_q, busy_d;

  logic       pix_en;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic [2:0] pix_colour;
  logic       scan_last;
  logic       grant_enemy;
  logic       grant_player;

  assign scan_last    = (cx_q == CX_LAST) && (cy_q == CY_LAST);
  // On a tie the requester not served last wins.
  assign grant_enemy  = enemy_req && (!player_req || (last_grant_q == GRANT_PLAYER));
  assign grant_player = player_req && !grant_enemy;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    pix_en       = 1'b0;
    origin_x     = base_x_q;
    origin_y     = base_y_q;
    pix_colour   = BG_COLOUR;

    unique case (state_q)
      IDLE: begin
        if (grant_enemy) begin
          base_x_d     = enemy_x;
          base_y_d     = enemy_y;
          cx_d         = 4'd0;
          cy_d         = 4'd0;
          last_grant_d = GRANT_ENEMY;
          state_d      = prev_valid_q ? E_ERASE : E_DRAW;
        end else if (grant_player) begin
          base_x_d     = player_x;
          base_y_d     = player_y;
          cx_d         = 4'd0;
          cy_d         = 4'd0;
          last_grant_d = GRANT_PLAYER;
          state_d      = P_DRAW;
        end
      end
      E_ERASE: begin
        pix_en     = 1'b1;
        origin_x   = prev_x_q;
        origin_y   = prev_y_q;
        pix_colour = BG_COLOUR;
        if (scan_last) state_d = E_DRAW;
      end
      E_DRAW: begin
        pix_en     = 1'b1;
        pix_colour = ENEMY_COLOUR;
        if (scan_last) begin
          state_d      = DONE;
          prev_x_d     = base_x_q;
          prev_y_d     = base_y_q;
          prev_valid_d = 1'b1;
        end
      end
      P_DRAW: begin
        pix_en     = 1'b1;
        pix_colour = PLAYER_COLOUR;
        if (scan_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Raster advance; wrapping both counters leaves them cleared for the next pass.
    if (pix_en) begin
      if (cx_q == CX_LAST) begin
        cx_d = 4'd0;
        cy_d = (cy_q == CY_LAST) ? 4'd0 : cy_q + 4'd1;
      end else begin
        cx_d = cx_q + 4'd1;
      end
    end
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    write_en_d   = pix_en;
    enemy_ack_d  = (state_q == DONE) && (last_grant_q == GRANT_ENEMY);
    player_ack_d = (state_q == DONE) && (last_grant_q == GRANT_PLAYER);
    busy_d       = (state_q != IDLE);
    if (pix_en) begin
      x_d      = origin_x + {4'd0, cx_q};
      y_d      = origin_y + {3'd0, cy_q};
      colour_d = pix_colour;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_PLAYER;
      cx_q         <= 4'd0;
      cy_q         <= 4'd0;
      base_x_q     <= 8'd0;
      base_y_q     <= 7'd0;
      prev_x_q     <= 8'd0;
      prev_y_q     <= 7'd0;
      prev_valid_q <= 1'b0;
      x_q          <= 8'd0;
      y_q          <= 7'd0;
      colour_q     <= 3'd0;
      write_en_q   <= 1'b0;
      enemy_ack_q  <= 1'b0;
      player_ack_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      write_en_q   <= write_en_d;
      enemy_ack_q  <= enemy_ack_d;
      player_ack_q <= player_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour     = colour_q;
  assign writeEn    = write_en_q;
  assign enemy_ack  = enemy_ack_q;
  assign player_ack = player_ack_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_enemy_draw_scheduler.sv
// Directed bench for enemy_draw_scheduler with 4x4 boxes: pixel streams,
// erase passes, round-robin ties, coordinate wrap and mid-scan reset.
module tb_enemy_draw_scheduler;

  localparam int         BW       = 4;
  localparam int         BH       = 4;
  localparam logic [2:0] BG_C     = 3'b000;
  localparam logic [2:0] ENEMY_C  = 3'b100;
  localparam logic [2:0] PLAYER_C = 3'b010;

  logic       clock;
  logic       reset_n;
  logic       enemy_req;
  logic [7:0] enemy_x;
  logic [6:0] enemy_y;
  logic       player_req;
  logic [7:0] player_x;
  logic [6:0] player_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       writeEn;
  logic       enemy_ack;
  logic       player_ack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  enemy_draw_scheduler #(
    .BOX_W        (BW),
    .BOX_H        (BH),
    .BG_COLOUR    (BG_C),
    .ENEMY_COLOUR (ENEMY_C),
    .PLAYER_COLOUR(PLAYER_C)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enemy_req (enemy_req),
    .enemy_x   (enemy_x),
    .enemy_y   (enemy_y),
    .player_req(player_req),
    .player_x  (player_x),
    .player_y  (player_y),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .writeEn   (writeEn),
    .enemy_ack (enemy_ack),
    .player_ack(player_ack),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for the first pixel and checks how many cycles it took.
  task automatic wait_first(input string tag, input int exp_delay);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (writeEn !== 1'b1 && n < 20);
    check({tag, "_first_pixel_delay"}, n, exp_delay);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  // Checks npix consecutive pixels of a raster pass starting at the current negedge.
  task automatic expect_pass(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                             input logic [2:0] col, input int npix);
    for (int i = 0; i < npix; i++) begin
      check($sformatf("%s_we%0d", tag, i), writeEn, 1'b1);
      check($sformatf("%s_x%0d", tag, i), x_out, 8'(x0 + (i % BW)));
      check($sformatf("%s_y%0d", tag, i), y_out, 7'(y0 + (i / BW)));
      check($sformatf("%s_c%0d", tag, i), colour, col);
      @(negedge clock);
    end
  endtask

  // Ack cycle, then the following idle cycle; the served request drops on ack.
  task automatic expect_ack(input string tag, input logic e, input logic p);
    check({tag, "_ack_we"}, writeEn, 1'b0);
    check({tag, "_enemy_ack"}, enemy_ack, e);
    check({tag, "_player_ack"}, player_ack, p);
    check({tag, "_ack_busy"}, busy, 1'b1);
    if (e) enemy_req = 1'b0;
    if (p) player_req = 1'b0;
    @(negedge clock);
    check({tag, "_post_we"}, writeEn, 1'b0);
    check({tag, "_post_enemy_ack"}, enemy_ack, 1'b0);
    check({tag, "_post_player_ack"}, player_ack, 1'b0);
    check({tag, "_post_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    enemy_req  = 1'b0;
    enemy_x    = 8'd0;
    enemy_y    = 7'd0;
    player_req = 1'b0;
    player_x   = 8'd0;
    player_y   = 7'd0;
    repeat (2) @(negedge clock);
    check("rst_x", x_out, 8'd0);
    check("rst_y", y_out, 7'd0);
    check("rst_colour", colour, 3'd0);
    check("rst_we", writeEn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {enemy_ack, player_ack}, 2'b00);
    reset_n = 1'b1;
    @(negedge clock);

    // First enemy draw: no previous box, so no erase pass.
    enemy_req = 1'b1; enemy_x = 8'd20; enemy_y = 7'd8;
    wait_first("e1", 2);
    expect_pass("e1_draw", 8'd20, 7'd8, ENEMY_C, 16);
    expect_ack("e1", 1'b1, 1'b0);
    check("e1_prev_valid", dut.prev_valid_q, 1'b1);

    // Second enemy draw: erase old box then draw new one back to back.
    enemy_req = 1'b1; enemy_x = 8'd60; enemy_y = 7'd8;
    wait_first("e2", 2);
    expect_pass("e2_erase", 8'd20, 7'd8, BG_C, 16);
    expect_pass("e2_draw", 8'd60, 7'd8, ENEMY_C, 16);
    expect_ack("e2", 1'b1, 1'b0);

    // Player box wrapping in both axes; leaves last grant on the player.
    player_req = 1'b1; player_x = 8'd254; player_y = 7'd126;
    wait_first("p1", 2);
    expect_pass("p1_draw", 8'd254, 7'd126, PLAYER_C, 16);
    expect_ack("p1", 1'b0, 1'b1);

    // Simultaneous requests, twice: enemy, player, enemy, player.
    enemy_req = 1'b1; enemy_x = 8'd40; enemy_y = 7'd30;
    player_req = 1'b1; player_x = 8'd10; player_y = 7'd100;
    wait_first("tie1_e", 2);
    expect_pass("tie1_e_erase", 8'd60, 7'd8, BG_C, 16);
    expect_pass("tie1_e_draw", 8'd40, 7'd30, ENEMY_C, 16);
    expect_ack("tie1_e", 1'b1, 1'b0);
    wait_first("tie1_p", 1);
    expect_pass("tie1_p_draw", 8'd10, 7'd100, PLAYER_C, 16);
    expect_ack("tie1_p", 1'b0, 1'b1);

    enemy_req = 1'b1; enemy_x = 8'd80; enemy_y = 7'd40;
    player_req = 1'b1; player_x = 8'd12; player_y = 7'd90;
    wait_first("tie2_e", 2);
    expect_pass("tie2_e_erase", 8'd40, 7'd30, BG_C, 16);
    expect_pass("tie2_e_draw", 8'd80, 7'd40, ENEMY_C, 16);
    expect_ack("tie2_e", 1'b1, 1'b0);
    wait_first("tie2_p", 1);
    expect_pass("tie2_p_draw", 8'd12, 7'd90, PLAYER_C, 16);
    expect_ack("tie2_p", 1'b0, 1'b1);

    // Reset during the 10th pixel of an enemy draw pass.
    enemy_req = 1'b1; enemy_x = 8'd100; enemy_y = 7'd50;
    wait_first("rs", 2);
    expect_pass("rs_erase", 8'd80, 7'd40, BG_C, 16);
    expect_pass("rs_draw", 8'd100, 7'd50, ENEMY_C, 9);
    check("rs_pix10_we", writeEn, 1'b1);
    check("rs_pix10_x", x_out, 8'd101);
    check("rs_pix10_y", y_out, 7'd52);
    reset_n = 1'b0;
    enemy_req = 1'b0;
    #1;
    check("rs_we_low", writeEn, 1'b0);
    check("rs_busy_low", busy, 1'b0);
    check("rs_acks_low", {enemy_ack, player_ack}, 2'b00);
    check("rs_x_zero", x_out, 8'd0);
    check("rs_prev_valid", dut.prev_valid_q, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // After reset there is no previous box: draw only.
    enemy_req = 1'b1; enemy_x = 8'd30; enemy_y = 7'd20;
    wait_first("ar", 2);
    expect_pass("ar_draw", 8'd30, 7'd20, ENEMY_C, 16);
    expect_ack("ar", 1'b1, 1'b0);

    // Coordinates changed mid-scan must not disturb the latched box.
    enemy_req = 1'b1; enemy_x = 8'd120; enemy_y = 7'd60;
    wait_first("mc", 2);
    enemy_x = 8'd200; enemy_y = 7'd0;
    expect_pass("mc_erase", 8'd30, 7'd20, BG_C, 16);
    expect_pass("mc_draw", 8'd120, 7'd60, ENEMY_C, 16);
    expect_ack("mc", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_draw_scheduler.md
# enemy_draw_scheduler

Arbiter and sequencer for the single VGA plot port shared by the enemy and player sprites. It accepts redraw requests from the enemy control path and the player path, grants one at a time using round-robin, and latches the winner's coordinates. For an enemy redraw it first erases the previously drawn enemy box with the background colour, then draws the new box, emitting one pixel per clock. It sits between the enemy/player FSMs and the VGA adapter's x/y/colour/writeEn inputs.

## Interface

Parameters:
- BOX_W, 16, sprite box width in pixels (1..16)
- BOX_H, 16, sprite box height in pixels (1..16)
- BG_COLOUR, 3'b000, colour used for the erase pass
- ENEMY_COLOUR, 3'b100, enemy draw colour
- PLAYER_COLOUR, 3'b010, player draw colour

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enemy_req  in  1  level; enemy redraw wanted; held until enemy_ack
- enemy_x  in  8  top-left x of the new enemy box
- enemy_y  in  7  top-left y of the new enemy box
- player_req  in  1  level; player redraw wanted; held until player_ack
- player_x  in  8  top-left x of the player box
- player_y  in  7  top-left y of the player box
- x_out  out  8  plot x coordinate (registered)
- y_out  out  7  plot y coordinate (registered)
- colour  out  3  plot colour (registered)
- writeEn  out  1  plot strobe; one pixel per high cycle
- enemy_ack  out  1  one-cycle pulse when the enemy redraw completes
- player_ack  out  1  one-cycle pulse when the player redraw completes
- busy  out  1  high in every state except IDLE

## Operation

- States: IDLE, E_ERASE, E_DRAW, P_DRAW, DONE.
- IDLE behaviour:
  - Only enemy_req: grant enemy.
  - Only player_req: grant player.
  - Both: grant the requester that was not granted last. After reset, last_grant is player, so the enemy wins the first tie.
- At grant:
  - Latch the requester's x/y into base registers.
  - Clear the pixel counters cx and cy.
  - Update last_grant.
- Enemy grant:
  - Go to E_ERASE if a valid previous enemy box exists (prev_valid = 1); otherwise go to E_DRAW.
  - E_ERASE scans the box at prev_x/prev_y with BG_COLOUR.
  - E_DRAW then scans the box at the latched base with ENEMY_COLOUR.
  - On leaving E_DRAW, copy base into prev_x/prev_y and set prev_valid to 1.
- Player grant: go to P_DRAW, which scans with PLAYER_COLOUR. Player boxes are never erased by this block.
- Scan order:
  - cx counts 0..BOX_W-1 and is the inner loop; cy counts 0..BOX_H-1 and is the outer loop.
  - x_out = origin_x + cx, truncated mod 256. y_out = origin_y + cy, truncated mod 128. Off-screen wrap is the requester's responsibility.
  - After pixel (BOX_W-1, BOX_H-1) the state advances (E_ERASE→E_DRAW with counters cleared, E_DRAW/P_DRAW→DONE).
- DONE:
  - Pulse the ack of the granted requester for one cycle with writeEn = 0, then return to IDLE.
  - If req is still high in the cycle after ack, it is treated as a new request.
- Request inputs are ignored while busy. Coordinates are sampled only at grant, so changes mid-scan have no effect.
- Reset (asynchronous, any state, including mid-scan):
  - State goes to IDLE; counters, prev_x/prev_y, x_out, y_out and colour go to 0.
  - writeEn, both acks, busy and prev_valid go to 0.
  - last_grant goes to player.
  - The partial box is not completed.

## Timing

- Request seen in IDLE at edge k: first pixel is presented (writeEn = 1) after edge k+1.
- Exactly one pixel per cycle with no gaps. writeEn is high for BOX_W×BOX_H cycles per pass, and for 2×BOX_W×BOX_H cycles for an enemy redraw with erase.
- Ack latency:
  - Enemy with erase: ack high in the cycle after edge k+1+2·BOX_W·BOX_H.
  - Enemy without erase, or player: ack high in the cycle after edge k+1+BOX_W·BOX_H.
- busy rises after edge k+1 and falls after the edge ending DONE.
- Minimum spacing between two grants: one IDLE cycle.
- colour and writeEn change on the same edge as x_out/y_out, so all four are coherent each cycle.

## Test plan

Bench uses BOX_W = 4, BOX_H = 4.

- Reset, then enemy_req with (20,8) → 16 pixels at x 20..23, y 8..11, colour 100, no erase pass; enemy_ack pulses once; prev_valid = 1.
- Second enemy_req with (60,8) → 16 BG pixels at (20..23, 8..11), then 16 colour-100 pixels at (60..63, 8..11), back to back; ack after 32 writes.
- enemy_req and player_req asserted on the same cycle, repeated twice → grant order enemy, player, enemy, player; acks never overlap; writeEn gaps are exactly one DONE and one IDLE cycle.
- player_req with (254,126) → x wraps 254, 255, 0, 1 and y wraps 126, 127, 0, 1; colour 010.
- Assert reset_n low during the 10th pixel of an enemy draw → writeEn, busy and ack go low immediately; the next enemy_req draws with no erase pass.
- Change enemy_x during a scan → scanned coordinates remain the latched values.
